id_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 82 ++++++++
 rtl/id_stage_reg_file.sv | 40 ++++
 rtl/id_stage.sv | 158 +++++++++++++++
 tb/tb_id_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode map, control/pipeline-register types and the instruction decoder
// for the MIPS-lite pipeline.
package mips_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_SUBI = 6'h03;
  localparam logic [5:0] OP_MUL  = 6'h04;
  localparam logic [5:0] OP_MULI = 6'h05;
  localparam logic [5:0] OP_OR   = 6'h06;
  localparam logic [5:0] OP_ORI  = 6'h07;
  localparam logic [5:0] OP_AND  = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h09;
  localparam logic [5:0] OP_XOR  = 6'h0A;
  localparam logic [5:0] OP_XORI = 6'h0B;
  localparam logic [5:0] OP_LDW  = 6'h0C;
  localparam logic [5:0] OP_STW  = 6'h0D;
  localparam logic [5:0] OP_BZ   = 6'h0E;
  localparam logic [5:0] OP_BEQ  = 6'h0F;
  localparam logic [5:0] OP_JR   = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic halt;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dest;
    ctrl_t       ctrl;
  } idex_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [4:0] dest;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [4:0] rt,
                                  input logic [4:0] rd);
    dec_t d;
    d = '0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
        d.ctrl.reg_write = 1'b1;
        d.dest           = rd;
      end
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
        d.ctrl.reg_write = 1'b1;
        d.dest           = rt;
      end
      OP_LDW: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.mem_read  = 1'b1;
        d.dest           = rt;
      end
      OP_STW:               d.ctrl.mem_write = 1'b1;
      OP_BZ, OP_BEQ, OP_JR: d.ctrl.branch    = 1'b1;
      OP_HALT:              d.ctrl.halt      = 1'b1;
      default:              d.illegal        = 1'b1;
    endcase
    // R0 is never a real destination, so it must not look like one to hazard logic
    if (d.dest == '0) d.ctrl.reg_write = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// NREGS x 32 register file: two combinational read ports with write-first bypass,
// one synchronous write port, R0 hardwired to zero.
module reg_file
  import mips_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [31:0]   o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [31:0]   o_rdata_b
);

  logic [31:0] r_regs [NREGS];
  logic        w_wr_en;

  assign w_wr_en = i_we && (i_waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata_a = '0;
    o_rdata_b = '0;
    if (i_raddr_a != '0) o_rdata_a = (w_wr_en && i_waddr == i_raddr_a) ? i_wdata : r_regs[i_raddr_a];
    if (i_raddr_b != '0) o_rdata_b = (w_wr_en && i_waddr == i_raddr_b) ? i_wdata : r_regs[i_raddr_b];
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, decode, register-file read, ID/EX
// register, HALT tracking and issue/bubble performance counters.
module id_stage
  import mips_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_instruction,
  input  logic [31:0]      if_pc,
  input  logic             stall,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [4:0]       wb_dest,
  input  logic [31:0]      wb_data,
  output logic [4:0]       rs_f_id,
  output logic [4:0]       rt_f_id,
  output logic [4:0]       rd_f_id,
  output logic [4:0]       id_dest,
  output logic             reg_write_f_id,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [5:0]       ex_opcode,
  output logic [31:0]      ex_rs_val,
  output logic [31:0]      ex_rt_val,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_dest,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_halt,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] bubble_count
);

  logic [31:0]      r_ifid_instr;
  logic [31:0]      r_ifid_pc;
  logic             r_ifid_valid;
  idex_t            r_idex;
  idex_t            w_idex_d;
  state_t           r_state;
  state_t           w_state_next;
  dec_t             w_dec;
  logic             w_issue;
  logic [31:0]      w_rs_val;
  logic [31:0]      w_rt_val;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instr_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  assign w_dec   = decode(r_ifid_instr[31:26], r_ifid_instr[20:16], r_ifid_instr[15:11]);
  assign w_issue = r_ifid_valid && !flush && !stall && (r_state == ST_RUN);

  reg_file #(.NREGS(NREGS)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_we      (wb_we),
    .i_waddr   (wb_dest),
    .i_wdata   (wb_data),
    .i_raddr_a (r_ifid_instr[25:21]),
    .o_rdata_a (w_rs_val),
    .i_raddr_b (r_ifid_instr[20:16]),
    .o_rdata_b (w_rt_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else if (flush) begin
      r_ifid_valid <= 1'b0;
    end else if (stall) begin
      r_ifid_valid <= r_ifid_valid;
    end else if (r_state == ST_HALTED) begin
      r_ifid_valid <= 1'b0;
    end else begin
      r_ifid_instr <= if_instruction;
      r_ifid_pc    <= if_pc;
      r_ifid_valid <= 1'b1;
    end
  end

  always_comb begin
    w_idex_d = '0;
    if (w_issue) begin
      w_idex_d.valid  = 1'b1;
      w_idex_d.pc     = r_ifid_pc;
      w_idex_d.opcode = r_ifid_instr[31:26];
      w_idex_d.rs_val = w_rs_val;
      w_idex_d.rt_val = w_rt_val;
      w_idex_d.imm    = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
      w_idex_d.dest   = w_dec.dest;
      w_idex_d.ctrl   = w_dec.ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_idex <= '0;
    else     r_idex <= w_idex_d;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:    if (w_issue && w_dec.ctrl.halt) w_state_next = ST_HALTED;
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal    <= 1'b0;
      r_instr_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_issue && w_dec.illegal) r_illegal <= 1'b1;
      if (w_issue && r_instr_cnt != '1) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      if (stall && !flush && r_state == ST_RUN && r_bubble_cnt != '1)
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign rs_f_id        = r_ifid_instr[25:21];
  assign rt_f_id        = r_ifid_instr[20:16];
  assign rd_f_id        = r_ifid_instr[15:11];
  assign id_dest        = r_ifid_valid ? w_dec.dest : 5'd0;
  assign reg_write_f_id = r_ifid_valid && w_dec.ctrl.reg_write;

  assign ex_valid     = r_idex.valid;
  assign ex_pc        = r_idex.pc;
  assign ex_opcode    = r_idex.opcode;
  assign ex_rs_val    = r_idex.rs_val;
  assign ex_rt_val    = r_idex.rt_val;
  assign ex_imm       = r_idex.imm;
  assign ex_dest      = r_idex.dest;
  assign ex_reg_write = r_idex.ctrl.reg_write;
  assign ex_mem_read  = r_idex.ctrl.mem_read;
  assign ex_mem_write = r_idex.ctrl.mem_write;
  assign ex_branch    = r_idex.ctrl.branch;
  assign ex_halt      = r_idex.ctrl.halt;
  assign halted       = (r_state == ST_HALTED);
  assign illegal_op   = r_illegal;
  assign instr_count  = r_instr_cnt;
  assign bubble_count = r_bubble_cnt;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: reset, bypass, stall, flush, HALT
// and illegal-opcode scenarios with hand-computed expectations.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_instruction = '0;
  logic [31:0] if_pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_dest = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  rs_f_id, rt_f_id, rd_f_id, id_dest, ex_dest;
  logic        reg_write_f_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_halt, halted, illegal_op;
  logic [31:0] ex_pc, ex_rs_val, ex_rt_val, ex_imm;
  logic [5:0]  ex_opcode;
  logic [31:0] instr_count, bubble_count;

  int n_cmp = 0;
  int n_err = 0;

  id_stage #(.NREGS(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .if_instruction(if_instruction), .if_pc(if_pc),
    .stall(stall), .flush(flush), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .rs_f_id(rs_f_id), .rt_f_id(rt_f_id), .rd_f_id(rd_f_id), .id_dest(id_dest),
    .reg_write_f_id(reg_write_f_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_opcode(ex_opcode), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_halt(ex_halt),
    .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_instruction = '0; if_pc = '0; stall = 0; flush = 0;
    wb_we = 0; wb_dest = '0; wb_data = '0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    step(); step(); step();
    n_cmp++; if (instr_count !== 32'd2) begin n_err++; $display("FAIL rst_pre_count: got %0d want 2", instr_count); end
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b want 1", ex_valid); end
    #3 rst = 1;
    #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b want 0", ex_valid); end
    n_cmp++; if (instr_count !== 32'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", instr_count); end
    n_cmp++; if ({ex_pc, ex_rs_val, ex_rt_val, ex_imm} !== 128'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", {ex_pc, ex_rs_val, ex_rt_val, ex_imm}); end
    n_cmp++; if ({ex_dest, ex_opcode, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_halt, halted, illegal_op, reg_write_f_id} !== 19'd0) begin
      n_err++; $display("FAIL rst_ctrl: got %h want 0", {ex_dest, ex_opcode, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_halt, halted, illegal_op, reg_write_f_id}); end
    step();
    n_cmp++; if ({ex_valid, bubble_count} !== 33'd0) begin n_err++; $display("FAIL rst_held: got %h want 0", {ex_valid, bubble_count}); end
    rst = 0;
    wb_we = 1; wb_dest = 5'd5; wb_data = 32'h1234;
    if_instruction = itype(6'h01, 5'd5, 5'd6, 16'hFFFF); if_pc = 32'h100;
    step();
    wb_we = 0; if_instruction = '0; if_pc = 32'h104;
    step();
    n_cmp++; if (ex_rs_val !== 32'h1234) begin n_err++; $display("FAIL addi_rs: got %h want 00001234", ex_rs_val); end
    n_cmp++; if (ex_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_imm: got %h want ffffffff", ex_imm); end
    n_cmp++; if ({ex_valid, ex_reg_write, ex_dest, ex_pc} !== {1'b1, 1'b1, 5'd6, 32'h100}) begin
      n_err++; $display("FAIL addi_ctrl: got %b %b %0d %h want 1 1 6 00000100", ex_valid, ex_reg_write, ex_dest, ex_pc); end
  endtask

  task automatic test_bypass();
    do_reset();
    if_instruction = rtype(6'h00, 5'd1, 5'd2, 5'd3); if_pc = 32'h200;
    step();
    n_cmp++; if ({rs_f_id, rt_f_id, rd_f_id} !== {5'd1, 5'd2, 5'd3}) begin n_err++; $display("FAIL byp_fields: got %0d %0d %0d want 1 2 3", rs_f_id, rt_f_id, rd_f_id); end
    n_cmp++; if ({id_dest, reg_write_f_id} !== {5'd3, 1'b1}) begin n_err++; $display("FAIL byp_haz: got %0d %b want 3 1", id_dest, reg_write_f_id); end
    wb_we = 1; wb_dest = 5'd1; wb_data = 32'd7;
    if_instruction = rtype(6'h00, 5'd1, 5'd1, 5'd4); if_pc = 32'h204;
    step();
    wb_we = 0; if_instruction = '0;
    n_cmp++; if ({ex_rs_val, ex_rt_val} !== {32'd7, 32'd0}) begin n_err++; $display("FAIL byp_vals: got %h %h want 7 0", ex_rs_val, ex_rt_val); end
    n_cmp++; if ({ex_dest, ex_reg_write, ex_pc} !== {5'd3, 1'b1, 32'h200}) begin n_err++; $display("FAIL byp_ctrl: got %0d %b %h want 3 1 200", ex_dest, ex_reg_write, ex_pc); end
    step();
    n_cmp++; if ({ex_rs_val, ex_rt_val, ex_dest} !== {32'd7, 32'd7, 5'd4}) begin n_err++; $display("FAIL byp_stored: got %h %h %0d want 7 7 4", ex_rs_val, ex_rt_val, ex_dest); end
  endtask

  task automatic test_stall();
    do_reset();
    if_instruction = itype(6'h0C, 5'd2, 5'd9, 16'h0004); if_pc = 32'h300;
    step();
    stall = 1; if_instruction = rtype(6'h02, 5'd1, 5'd1, 5'd8); if_pc = 32'h304;
    for (int i = 1; i <= 2; i++) begin
      step();
      n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL stall_bubble%0d: got %b want 0", i, ex_valid); end
      n_cmp++; if (bubble_count !== 32'(i)) begin n_err++; $display("FAIL stall_bcnt%0d: got %0d want %0d", i, bubble_count, i); end
      n_cmp++; if ({rt_f_id, id_dest} !== {5'd9, 5'd9}) begin n_err++; $display("FAIL stall_hold%0d: got %0d %0d want 9 9", i, rt_f_id, id_dest); end
    end
    stall = 0;
    step();
    n_cmp++; if ({ex_valid, ex_mem_read, ex_reg_write, ex_dest, ex_imm} !== {3'b111, 5'd9, 32'd4}) begin
      n_err++; $display("FAIL stall_ldw: got %b%b%b %0d %h want 111 9 4", ex_valid, ex_mem_read, ex_reg_write, ex_dest, ex_imm); end
    n_cmp++; if ({instr_count, bubble_count, ex_pc} !== {32'd1, 32'd2, 32'h300}) begin
      n_err++; $display("FAIL stall_cnt: got %0d %0d %h want 1 2 300", instr_count, bubble_count, ex_pc); end
  endtask

  task automatic test_flush();
    do_reset();
    if_instruction = itype(6'h0F, 5'd1, 5'd2, 16'h0010); if_pc = 32'h400;
    step();
    if_instruction = rtype(6'h02, 5'd3, 5'd4, 5'd5); if_pc = 32'h404;
    step();
    n_cmp++; if ({ex_branch, ex_reg_write, ex_dest, instr_count} !== {1'b1, 1'b0, 5'd0, 32'd1}) begin
      n_err++; $display("FAIL flush_beq: got %b %b %0d %0d want 1 0 0 1", ex_branch, ex_reg_write, ex_dest, instr_count); end
    flush = 1; stall = 1; if_instruction = '0; if_pc = 32'h408;
    step();
    flush = 0; stall = 0;
    n_cmp++; if ({ex_valid, instr_count, bubble_count} !== {1'b0, 32'd1, 32'd0}) begin
      n_err++; $display("FAIL flush_sq: got %b %0d %0d want 0 1 0", ex_valid, instr_count, bubble_count); end
    n_cmp++; if ({reg_write_f_id, id_dest} !== 6'd0) begin n_err++; $display("FAIL flush_ifid: got %b %0d want 0 0", reg_write_f_id, id_dest); end
    step();
    n_cmp++; if ({ex_valid, instr_count} !== {1'b0, 32'd1}) begin n_err++; $display("FAIL flush_nosub: got %b %0d want 0 1", ex_valid, instr_count); end
    step();
    n_cmp++; if ({ex_valid, ex_pc, instr_count} !== {1'b1, 32'h408, 32'd2}) begin n_err++; $display("FAIL flush_resume: got %b %h %0d want 1 408 2", ex_valid, ex_pc, instr_count); end
  endtask

  task automatic test_halt();
    do_reset();
    if_instruction = 32'h44000000; if_pc = 32'h500;
    step();
    n_cmp++; if ({halted, ex_halt} !== 2'b00) begin n_err++; $display("FAIL halt_pre: got %b %b want 0 0", halted, ex_halt); end
    if_instruction = rtype(6'h00, 5'd1, 5'd1, 5'd7); if_pc = 32'h504;
    step();
    n_cmp++; if ({ex_halt, ex_valid, ex_pc} !== {2'b11, 32'h500}) begin n_err++; $display("FAIL halt_issue: got %b %b %h want 1 1 500", ex_halt, ex_valid, ex_pc); end
    if_instruction = '0;
    wb_we = 1; wb_dest = 5'd7; wb_data = 32'hABCD;
    step();
    wb_we = 0;
    n_cmp++; if ({ex_halt, ex_valid, halted} !== 3'b001) begin n_err++; $display("FAIL halt_after: got %b %b %b want 0 0 1", ex_halt, ex_valid, halted); end
    n_cmp++; if (dut.u_rf.r_regs[7] !== 32'hABCD) begin n_err++; $display("FAIL halt_wb: got %h want 0000abcd", dut.u_rf.r_regs[7]); end
    step(); step();
    n_cmp++; if ({halted, ex_valid, reg_write_f_id, instr_count} !== {3'b100, 32'd1}) begin
      n_err++; $display("FAIL halt_sticky: got %b %b %b %0d want 1 0 0 1", halted, ex_valid, reg_write_f_id, instr_count); end
  endtask

  task automatic test_illegal();
    do_reset();
    if_instruction = 32'hFC000000; if_pc = 32'h600;
    step();
    n_cmp++; if ({illegal_op, reg_write_f_id} !== 2'b00) begin n_err++; $display("FAIL ill_pre: got %b %b want 0 0", illegal_op, reg_write_f_id); end
    if_instruction = itype(6'h01, 5'd3, 5'd0, 16'h0005); if_pc = 32'h604;
    step();
    n_cmp++; if ({illegal_op, ex_valid, ex_reg_write, ex_opcode} !== {3'b110, 6'h3F}) begin
      n_err++; $display("FAIL ill_op: got %b %b %b %h want 1 1 0 3f", illegal_op, ex_valid, ex_reg_write, ex_opcode); end
    n_cmp++; if ({reg_write_f_id, id_dest} !== 6'd0) begin n_err++; $display("FAIL ill_r0haz: got %b %0d want 0 0", reg_write_f_id, id_dest); end
    if_instruction = rtype(6'h00, 5'd0, 5'd0, 5'd1); if_pc = 32'h608;
    wb_we = 1; wb_dest = 5'd0; wb_data = 32'hDEAD;
    step();
    n_cmp++; if ({ex_valid, ex_reg_write, ex_dest, illegal_op} !== {2'b10, 5'd0, 1'b1}) begin
      n_err++; $display("FAIL ill_addi_r0: got %b %b %0d %b want 1 0 0 1", ex_valid, ex_reg_write, ex_dest, illegal_op); end
    if_instruction = '0;
    step();
    wb_we = 0;
    n_cmp++; if ({ex_rs_val, ex_rt_val} !== 64'd0) begin n_err++; $display("FAIL ill_r0_read: got %h %h want 0 0", ex_rs_val, ex_rt_val); end
    n_cmp++; if ({ex_reg_write, ex_dest} !== {1'b1, 5'd1}) begin n_err++; $display("FAIL ill_add_r1: got %b %0d want 1 1", ex_reg_write, ex_dest); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_stall();
    test_flush();
    test_halt();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
